// File: rtl/io_decoder.sv
// ============================================================================
// Module   : io_decoder
// Brief    : I/O port-space decoder routing sequencer strobes to four
//            peripheral slots, with ack/timeout completion tracking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_decoder #(
    parameter logic [63:0] DEV_BASE = 64'h0000_0000_0000_0000,
    parameter logic [63:0] DEV_MASK = 64'h0000_0000_0000_0000,
    parameter logic [3:0]  DEV_IO32 = 4'b0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   bus_address,
    input  logic          bus_read,
    input  logic          bus_write,
    input  logic [2:0]    bus_datasize,
    input  logic [31:0]   bus_writedata,
    output logic [31:0]   bus_readdata,
    output logic          bus_wait,
    output logic          bus_io32,
    output logic [3:0]    dev_read,
    output logic [3:0]    dev_write,
    output logic [15:0]   dev_address,
    output logic [2:0]    dev_datasize,
    output logic [31:0]   dev_writedata,
    input  logic [127:0]  dev_readdata,
    input  logic [3:0]    dev_ack,
    output logic          timeout_err,
    output logic [15:0]   timeout_port
);

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        strobe;
    logic [3:0]  hit;
    logic        hit_any;
    logic [1:0]  sel_next;
    logic [1:0]  sel;
    logic        is_write;
    logic [15:0] count;
    logic        ack_sel;
    logic        timed_out;

    assign strobe    = bus_read | bus_write;
    assign hit_any   = |hit;
    assign ack_sel   = dev_ack[sel];
    assign timed_out = (count == TIMEOUT_CNT);
    assign bus_wait  = (state == BUSY);

    // A slot with an all-zero mask would match everything, so it is disabled.
    always_comb begin
        hit = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            hit[n] = (DEV_MASK[16*n +: 16] != 16'h0000) &&
                     ((bus_address & DEV_MASK[16*n +: 16]) ==
                      (DEV_BASE[16*n +: 16] & DEV_MASK[16*n +: 16]));
        end
    end

    // Descending scan so the lowest matching slot wins.
    always_comb begin
        sel_next = 2'd0;
        for (int n = 3; n >= 0; n--) begin
            if (hit[n]) begin
                sel_next = 2'(n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (strobe && hit_any) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (ack_sel || timed_out) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_readdata  <= 32'h0000_0000;
            bus_io32      <= 1'b0;
            dev_read      <= 4'b0000;
            dev_write     <= 4'b0000;
            dev_address   <= 16'h0000;
            dev_datasize  <= 3'd0;
            dev_writedata <= 32'h0000_0000;
            timeout_err   <= 1'b0;
            timeout_port  <= 16'h0000;
            sel           <= 2'd0;
            is_write      <= 1'b0;
            count         <= 16'h0000;
        end else begin
            dev_read  <= 4'b0000;
            dev_write <= 4'b0000;
            if (state == IDLE && strobe) begin
                dev_address   <= bus_address;
                dev_datasize  <= bus_datasize;
                dev_writedata <= bus_writedata;
                is_write      <= bus_write;
                sel           <= sel_next;
                count         <= 16'h0000;
                bus_io32      <= hit_any ? DEV_IO32[sel_next] : 1'b0;
                if (hit_any) begin
                    // Write takes priority when both strobes arrive together.
                    if (bus_write) begin
                        dev_write <= 4'b0001 << sel_next;
                    end else begin
                        dev_read  <= 4'b0001 << sel_next;
                    end
                end else if (!bus_write) begin
                    bus_readdata <= 32'hFFFF_FFFF;
                end
            end else if (state == BUSY) begin
                if (ack_sel) begin
                    if (!is_write) begin
                        bus_readdata <= dev_readdata[{sel, 5'b00000} +: 32];
                    end
                end else if (timed_out) begin
                    if (!is_write) begin
                        bus_readdata <= 32'hFFFF_FFFF;
                    end
                    timeout_err  <= 1'b1;
                    timeout_port <= dev_address;
                end else begin
                    count <= count + 16'h0001;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/io_decoder.md
# io_decoder

Port-space decoder and completion tracker sitting directly downstream of the CPU I/O byte-sequencer. It takes one read or write strobe at a time on the sequencer-facing bus and routes it to one of four peripheral slots by address/mask match. It holds `bus_wait` until the selected peripheral acknowledges, and reports whether that peripheral accepts whole 32-bit accesses via `bus_io32`. Unmapped ports and peripherals that never acknowledge complete with all-ones data, so the sequencer never hangs.

## Interface
- `DEV_BASE`, default 64'h0000_0000_0000_0000, packed {base3,base2,base1,base0}, 16-bit port base per slot
- `DEV_MASK`, default 64'h0000_0000_0000_0000, packed per slot; a 1 bit means that address bit is compared; an all-zero mask disables the slot
- `DEV_IO32`, default 4'b0000, bit n = slot n handles a full `bus_datasize` access in one strobe
- `TIMEOUT`, default 255, cycles to wait for `dev_ack` before forced completion (1..65535)

Ports:
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `bus_address` in 16: port address, valid in the strobe cycle
- `bus_read` in 1: one-cycle read strobe
- `bus_write` in 1: one-cycle write strobe
- `bus_datasize` in 3: access size in bytes (1..4)
- `bus_writedata` in 32: write data, byte 0 in [7:0]
- `bus_readdata` out 32: read result, held until the next completed read
- `bus_wait` out 1: transaction in progress
- `bus_io32` out 1: selected slot's `DEV_IO32` bit; 0 for unmapped
- `dev_read` out 4: one-hot one-cycle read strobe
- `dev_write` out 4: one-hot one-cycle write strobe
- `dev_address` out 16: latched port address
- `dev_datasize` out 3: latched size
- `dev_writedata` out 32: latched write data
- `dev_readdata` in 128: packed per-slot read data, sampled with `dev_ack`
- `dev_ack` in 4: per-slot completion pulse
- `timeout_err` out 1: sticky; set on any timeout, cleared only by reset
- `timeout_port` out 16: address of the most recent timed-out access

## Operation
- States:
  - IDLE: no transaction in progress.
  - BUSY: waiting for `dev_ack` or timeout.
- IDLE, strobe sampled (`bus_read|bus_write`):
  - Latch `dev_address`, `dev_datasize` and `dev_writedata`.
  - Select slot: the lowest n with `(bus_address & MASK[n]) == (BASE[n] & MASK[n])` and `MASK[n] != 0`.
- Mapped slot: next cycle pulse `dev_read[n]` or `dev_write[n]`; `bus_wait`=1; `bus_io32`=`DEV_IO32[n]`; go to BUSY; counter=0.
- Unmapped: no dev strobe; `bus_wait` stays 0; `bus_io32`=0.
  - On a read, `bus_readdata`=32'hFFFF_FFFF next cycle.
  - On a write, the data is dropped.
  - Remain in IDLE.
- Both strobes in one cycle: write wins; read ignored.
- BUSY, `dev_ack[sel]` sampled:
  - On a read, `bus_readdata` = slot's 32-bit lane.
  - `bus_wait`=0 next cycle; return to IDLE.
  - `dev_ack` from non-selected slots is ignored.
- BUSY, no ack:
  - Counter increments each cycle.
  - When the counter reaches `TIMEOUT`, complete as if acked: read data 32'hFFFF_FFFF, `timeout_err`=1, `timeout_port`=`dev_address`.
- Strobes arriving in BUSY are ignored (protocol violation, no side effects).
- `bus_io32` holds its value until the next strobe is decoded.
- Reset, including mid-transaction: abort to IDLE, no completion pulse. All outputs are 0: `bus_readdata`, `bus_wait`, `bus_io32`, `dev_read`, `dev_write`, `dev_address`, `dev_datasize`, `dev_writedata`, `timeout_err`, `timeout_port`.

## Timing
- Strobe in cycle T:
  - `dev_*` strobe, latched fields, `bus_wait` and `bus_io32` are valid in T+1.
  - The sequencer samples `bus_wait`, `bus_readdata` and `bus_io32` at T+2 and later.
- `dev_ack` may be asserted from T+1 onward, including the same cycle as the `dev_*` strobe.
- Ack sampled at end of cycle A: `bus_readdata` valid and `bus_wait`=0 in A+1. The minimum transaction is therefore ack at T+1, with `bus_wait` low at T+2.
- Timeout: the strobe is at T+1, and forced completion gives `bus_wait`=0 at T+2+`TIMEOUT`.
- Unmapped: `bus_wait` is never asserted; read data is valid at T+1.
- Back-to-back strobes: a new strobe is accepted in the same cycle `bus_wait` falls.

## Test plan
- Slot0 BASE 16'h0060, MASK 16'hFFFE, IO32 0. Read 1 byte at 16'h0061, ack at T+3 with lane0 32'h0000_00A5 -> `dev_read`=4'b0001 at T+1; `bus_wait` high T+1..T+3, low T+4; `bus_readdata`=32'h0000_00A5; `bus_io32`=0.
- Slot2 IO32=1 at 16'h0CF8/FFFC. Write 4 bytes 32'h8000_0800, ack same cycle as strobe -> `dev_write`=4'b0100 at T+1; `dev_writedata`=32'h8000_0800; `bus_io32`=1; `bus_wait` low at T+2.
- Read 16'h0400 (unmapped) -> no dev strobe; `bus_wait` never 1; `bus_readdata`=32'hFFFF_FFFF at T+1.
- `TIMEOUT`=4, slot1 never acks; read at 16'h0070 -> `bus_wait` low at T+6; data 32'hFFFF_FFFF; `timeout_err`=1; `timeout_port`=16'h0070.
- Slots 0 and 1 both match 16'h0020 -> only `dev_read[0]` pulses. Slot1 `dev_ack` during BUSY is ignored; slot0 ack completes.
- Reset asserted in BUSY -> all outputs 0 next cycle. A late `dev_ack` after reset has no effect, and the next strobe decodes normally.
